slot_timing_generator: RTL and testbench
========================================

Name: slot_timing_generator

Overview:
Parametrised successor to the fixed 32-slot OPM timing generator, for FM cores with any power-of-two slot count and channel/operator split. Divides the phiM clock enable into phi1 positive/negative enables and runs a slot counter. Drives channel/operator indices, run-time-programmable mask/compare decode taps, and SH1/SH2 sample-hold strobes with configurable delay. Sits at the top of each core and feeds every slot-synchronous pipeline (REG, PG, EG, OP, ACC, LFO, NOISE).

Parameters:
SLOTS, 32, slots per sample frame; power of two, 8..256; CW = clog2(SLOTS)
CHANNELS, 8, channels per frame; power of two, divides SLOTS; OPS = SLOTS/CHANNELS
PRESCALE, 2, phiM enables per phi1 period; even, 2..16
NTAPS, 16, number of programmable decode taps
SH_DELAY, 5, register stages between SH window decode and SH outputs; 1..15

Ports:
i_EMUCLK  in  1  emulator master clock, all logic on posedge
i_RST  in  1  synchronous active-high reset
i_phiM_PCEN_n  in  1  phiM clock enable, active low
i_FREEZE  in  1  hold slot counter, taps and SH chain (debug single-step)
i_TAP_VAL  in  NTAPS*CW  compare value per tap, tap i at [i*CW +: CW]
i_TAP_MASK  in  NTAPS*CW  compare mask per tap; 1 = bit compared
o_MRST_n  out  1  core internal reset, active low
o_phi1  out  1  phi1 reference level
o_phi1_PCEN_n  out  1  phi1 positive-edge enable, active low
o_phi1_NCEN_n  out  1  phi1 negative-edge enable, active low
o_SLOT  out  CW  current slot counter
o_CH  out  clog2(CHANNELS)  slot mod CHANNELS
o_OP  out  clog2(OPS)  slot / CHANNELS
o_TAP  out  NTAPS  registered decode taps
o_SH1  out  1  sample-hold strobe 1
o_SH2  out  1  sample-hold strobe 2

Behaviour:
- Prescaler: phase counter 0..PRESCALE-1, advances on every cycle with i_phiM_PCEN_n low, wraps to 0.
- o_phi1 = 1 when phase < PRESCALE/2. o_phi1_PCEN_n = 0 only when phiM enable is active and phase == PRESCALE-1. o_phi1_NCEN_n = 0 only when phiM enable is active and phase == PRESCALE/2-1. Both enables are combinational from the phase register; each is exactly one EMUCLK cycle wide.
- "ncen tick" below means a cycle with o_phi1_NCEN_n low.
- i_RST high, any cycle:
  - phase = 0; slot = 0; o_MRST_n = 0; o_TAP = 0; SH chain = 0; o_SH1 = o_SH2 = 0.
  - Overrides i_FREEZE and a mid-frame state.
- Reset release: o_MRST_n rises at the first ncen tick after i_RST is sampled low. Slot stays 0 on that tick; counting starts on the next ncen tick.
- Slot counter: on each ncen tick with o_MRST_n = 1 and i_FREEZE = 0, slot increments, wrapping SLOTS-1 -> 0. Hold on all other cycles.
- o_CH = slot[clog2(CHANNELS)-1:0] and o_OP = slot[CW-1:clog2(CHANNELS)], combinational. When CHANNELS = SLOTS, o_OP is a 1-bit constant 0.
- Taps: on each non-frozen ncen tick, o_TAP[i] <= (((slot ^ VAL_i) & MASK_i) == 0). A tap therefore asserts for the ncen period after the slot matches. This gives the same one-ahead naming as the fixed generator: VAL = 11 yields "CYCLE_12".
  - MASK_i = 0 gives a tap that is constant 1 after its first update.
  - Tap values and masks may change at any time and take effect at the next ncen tick.
- SH windows: sh1 = slot in [SLOTS/4, SLOTS/2); sh2 = slot in [3*SLOTS/4, SLOTS).
  - Each window is shifted through a SH_DELAY-stage register chain on non-frozen ncen ticks.
  - o_SH1/o_SH2 = last chain stage AND o_MRST_n, registered on the same tick. Total SH latency is SH_DELAY+1 ticks.
- i_FREEZE: stops the slot counter, taps and SH chain, and all of their outputs hold. Prescaler, phi1 and the enables keep running. o_MRST_n is not affected by i_FREEZE.
- PRESCALE = 2 with the default parameters reproduces the 32-slot OPM timings exactly: SH1 asserted for slot-counter 13..20 after reset release, SH2 for 29..4.

Test Plan:
- SLOTS=32, PRESCALE=2, phiM enable every 4th EMUCLK, i_RST held 10 cycles and released -> phi1 period 8 EMUCLK; o_MRST_n rises at the first ncen tick; o_SLOT reads 0,1,…,31,0 on successive ticks.
- Defaults, tap0 VAL=11 MASK=5'h1F, tap1 VAL=5'b01110 MASK=5'b01111 -> tap0 high only while o_SLOT==12; tap1 high while o_SLOT==15 or 31.
- Defaults, SH_DELAY=5 -> o_SH1 high for exactly 8 ticks, while o_SLOT is 13..20; o_SH2 high while o_SLOT is 29..31 and 0..4; both low while o_MRST_n = 0.
- SLOTS=64, CHANNELS=16, PRESCALE=6 -> phi1 3 phiM enables high and 3 low; o_CH cycles 0..15 four times per frame; o_OP steps 0,1,2,3; SH1 window width 16 ticks.
- i_FREEZE high for 7 ticks at slot 20 -> o_SLOT, o_TAP and SH outputs hold; phi1 enables keep toggling; counting resumes at 21.
- i_RST pulsed 1 cycle at slot 17 with o_SH1 high -> on the next cycle o_SH1 = 0, o_SLOT = 0, o_TAP = 0, o_MRST_n = 0; normal release sequence follows.

Source files
------------

// File: rtl/slot_timing_generator.sv
// Slot timing generator: phi1 prescaler, slot counter, decode taps
// and sample-hold strobes feeding every slot-synchronous pipeline.
module slot_timing_generator #(
    parameter int SLOTS    = 32,
    parameter int CHANNELS = 8,
    parameter int PRESCALE = 2,
    parameter int NTAPS    = 16,
    parameter int SH_DELAY = 5,
    localparam int CW  = $clog2(SLOTS),
    localparam int CHW = $clog2(CHANNELS),
    localparam int OPS = SLOTS / CHANNELS,
    localparam int OPW = (OPS > 1) ? $clog2(OPS) : 1
) (
    input  logic                i_EMUCLK,
    input  logic                i_RST,
    input  logic                i_phiM_PCEN_n,
    input  logic                i_FREEZE,
    input  logic [NTAPS*CW-1:0] i_TAP_VAL,
    input  logic [NTAPS*CW-1:0] i_TAP_MASK,
    output logic                o_MRST_n,
    output logic                o_phi1,
    output logic                o_phi1_PCEN_n,
    output logic                o_phi1_NCEN_n,
    output logic [CW-1:0]       o_SLOT,
    output logic [CHW-1:0]      o_CH,
    output logic [OPW-1:0]      o_OP,
    output logic [NTAPS-1:0]    o_TAP,
    output logic                o_SH1,
    output logic                o_SH2
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PH_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PH_NEG  = PW'(PRESCALE / 2 - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(PRESCALE / 2);

    localparam logic [CW-1:0] Q1 = CW'(SLOTS / 4);
    localparam logic [CW-1:0] Q2 = CW'(SLOTS / 2);
    localparam logic [CW-1:0] Q3 = CW'(3 * SLOTS / 4);

    logic [PW-1:0]       phase;
    logic                phim;
    logic                ncen;
    logic                pcen;
    logic                step;
    logic [CW-1:0]       slot;
    logic [CW-1:0]       slot_nxt;
    logic [NTAPS-1:0]    tap_hit;
    logic                sh1_win;
    logic                sh2_win;
    logic [SH_DELAY-1:0] sh1_chain;
    logic [SH_DELAY-1:0] sh2_chain;

    assign phim = ~i_phiM_PCEN_n;
    assign ncen = phim && (phase == PH_NEG);
    assign pcen = phim && (phase == PH_LAST);
    assign step = ncen && !i_FREEZE;

    assign o_phi1        = (phase < PH_HALF);
    assign o_phi1_PCEN_n = ~pcen;
    assign o_phi1_NCEN_n = ~ncen;

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            phase <= '0;
        end else if (phim) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
        end
    end

    // Windows are decoded on the slot being entered, so the strobe
    // lands SH_DELAY slots after the window start on o_SLOT.
    assign slot_nxt = o_MRST_n ? slot + CW'(1) : slot;
    assign sh1_win  = (slot_nxt >= Q1) && (slot_nxt < Q2);
    assign sh2_win  = (slot_nxt >= Q3);

    always_comb begin
        tap_hit = '0;
        for (int i = 0; i < NTAPS; i++) begin
            tap_hit[i] = ((slot ^ i_TAP_VAL[i*CW +: CW])
                          & i_TAP_MASK[i*CW +: CW]) == '0;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            o_MRST_n  <= 1'b0;
            slot      <= '0;
            o_TAP     <= '0;
            sh1_chain <= '0;
            sh2_chain <= '0;
            o_SH1     <= 1'b0;
            o_SH2     <= 1'b0;
        end else begin
            if (ncen) begin
                o_MRST_n <= 1'b1;
            end
            if (step) begin
                slot      <= slot_nxt;
                o_TAP     <= tap_hit;
                sh1_chain <= (sh1_chain << 1) | SH_DELAY'(sh1_win);
                sh2_chain <= (sh2_chain << 1) | SH_DELAY'(sh2_win);
                o_SH1     <= sh1_chain[SH_DELAY-1] & o_MRST_n;
                o_SH2     <= sh2_chain[SH_DELAY-1] & o_MRST_n;
            end
        end
    end

    assign o_SLOT = slot;
    assign o_CH   = slot[CHW-1:0];

    generate
        if (OPS > 1) begin : g_op
            assign o_OP = slot[CW-1:CHW];
        end else begin : g_op_none
            assign o_OP = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_slot_timing_generator.sv
// Bench for slot_timing_generator: two configurations driven together
// and compared against a slot-arithmetic reference model.
module tb_slot_timing_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic pcen_n;
    logic frz;

    logic [16*5-1:0] tv0, tm0;
    logic [4*6-1:0]  tv1, tm1;

    logic        mrst0, phi10, pc0, nc0, sh10, sh20;
    logic [4:0]  slot0;
    logic [2:0]  ch0;
    logic [1:0]  op0;
    logic [15:0] tap0;

    logic        mrst1, phi11, pc1, nc1, sh11, sh21;
    logic [5:0]  slot1;
    logic [3:0]  ch1;
    logic [1:0]  op1;
    logic [3:0]  tap1;

    slot_timing_generator u_dut0 (
        .i_EMUCLK     (clk),
        .i_RST        (rst),
        .i_phiM_PCEN_n(pcen_n),
        .i_FREEZE     (frz),
        .i_TAP_VAL    (tv0),
        .i_TAP_MASK   (tm0),
        .o_MRST_n     (mrst0),
        .o_phi1       (phi10),
        .o_phi1_PCEN_n(pc0),
        .o_phi1_NCEN_n(nc0),
        .o_SLOT       (slot0),
        .o_CH         (ch0),
        .o_OP         (op0),
        .o_TAP        (tap0),
        .o_SH1        (sh10),
        .o_SH2        (sh20)
    );

    slot_timing_generator #(
        .SLOTS(64), .CHANNELS(16), .PRESCALE(6),
        .NTAPS(4), .SH_DELAY(3)
    ) u_dut1 (
        .i_EMUCLK     (clk),
        .i_RST        (rst),
        .i_phiM_PCEN_n(pcen_n),
        .i_FREEZE     (frz),
        .i_TAP_VAL    (tv1),
        .i_TAP_MASK   (tm1),
        .o_MRST_n     (mrst1),
        .o_phi1       (phi11),
        .o_phi1_PCEN_n(pc1),
        .o_phi1_NCEN_n(nc1),
        .o_SLOT       (slot1),
        .o_CH         (ch1),
        .o_OP         (op1),
        .o_TAP        (tap1),
        .o_SH1        (sh11),
        .o_SH2        (sh21)
    );

    int S[2]   = '{32, 64};
    int C[2]   = '{8, 16};
    int P[2]   = '{2, 6};
    int NT[2]  = '{16, 4};
    int SHD[2] = '{5, 3};

    int ph[2], sl[2], tp[2], hc[2], tk[2];
    bit mr[2], s1[2], s2[2];
    int hist[2][16];

    int n_chk = 0;
    int n_fail = 0;
    int gc = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    function automatic int tap_v(int d, int i);
        return d == 0 ? int'(tv0[i*5 +: 5]) : int'(tv1[i*6 +: 6]);
    endfunction

    function automatic int tap_m(int d, int i);
        return d == 0 ? int'(tm0[i*5 +: 5]) : int'(tm1[i*6 +: 6]);
    endfunction

    function automatic bit in_w(int d, int w, int x);
        if (w == 1) return x >= S[d] / 4 && x < S[d] / 2;
        return x >= 3 * S[d] / 4;
    endfunction

    task automatic mdl_edge(int d);
        bit nc;
        int ns, nt;
        nc = !pcen_n && ph[d] == P[d] / 2 - 1;
        if (rst) begin
            ph[d] = 0; sl[d] = 0; mr[d] = 0; tp[d] = 0;
            s1[d] = 0; s2[d] = 0; hc[d] = 0;
            return;
        end
        if (nc && !frz) begin
            nt = 0;
            for (int i = 0; i < NT[d]; i++)
                if (((sl[d] ^ tap_v(d, i)) & tap_m(d, i)) == 0)
                    nt |= (1 << i);
            tp[d] = nt;
            ns = mr[d] ? (sl[d] + 1) % S[d] : sl[d];
            for (int j = 15; j > 0; j--) hist[d][j] = hist[d][j-1];
            hist[d][0] = ns;
            if (hc[d] < 16) hc[d]++;
            s1[d] = mr[d] && hc[d] > SHD[d] && in_w(d, 1, hist[d][SHD[d]]);
            s2[d] = mr[d] && hc[d] > SHD[d] && in_w(d, 2, hist[d][SHD[d]]);
            sl[d] = ns;
        end
        if (nc) begin
            mr[d] = 1;
            tk[d]++;
        end
        if (!pcen_n) ph[d] = (ph[d] + 1) % P[d];
    endtask

    task automatic chk_comb();
        bit en;
        en = !pcen_n;
        chk("phi1_0", 32'(phi10), 32'(ph[0] < P[0] / 2));
        chk("pcen_0", 32'(pc0), 32'(!(en && ph[0] == P[0] - 1)));
        chk("ncen_0", 32'(nc0), 32'(!(en && ph[0] == P[0] / 2 - 1)));
        chk("ch_0", 32'(ch0), 32'(sl[0] % C[0]));
        chk("op_0", 32'(op0), 32'(sl[0] / C[0]));
        chk("phi1_1", 32'(phi11), 32'(ph[1] < P[1] / 2));
        chk("pcen_1", 32'(pc1), 32'(!(en && ph[1] == P[1] - 1)));
        chk("ncen_1", 32'(nc1), 32'(!(en && ph[1] == P[1] / 2 - 1)));
        chk("ch_1", 32'(ch1), 32'(sl[1] % C[1]));
        chk("op_1", 32'(op1), 32'(sl[1] / C[1]));
    endtask

    task automatic chk_regs();
        chk("mrst_0", 32'(mrst0), 32'(mr[0]));
        chk("slot_0", 32'(slot0), 32'(sl[0]));
        chk("tap_0", 32'(tap0), 32'(tp[0]));
        chk("sh1_0", 32'(sh10), 32'(s1[0]));
        chk("sh2_0", 32'(sh20), 32'(s2[0]));
        chk("mrst_1", 32'(mrst1), 32'(mr[1]));
        chk("slot_1", 32'(slot1), 32'(sl[1]));
        chk("tap_1", 32'(tap1), 32'(tp[1]));
        chk("sh1_1", 32'(sh11), 32'(s1[1]));
        chk("sh2_1", 32'(sh21), 32'(s2[1]));
    endtask

    // Entered at a negedge with inputs already driven.
    task automatic cyc();
        #1;
        chk_comb();
        @(posedge clk);
        mdl_edge(0);
        mdl_edge(1);
        #1;
        chk_regs();
        @(negedge clk);
        gc++;
    endtask

    task automatic drive_en(bit rnd);
        if (rnd) pcen_n = ($urandom_range(0, 2) != 0);
        else     pcen_n = (gc % 4 != 0);
    endtask

    task automatic rand_taps(bit keep);
        for (int i = (keep ? 3 : 0); i < 16; i++) begin
            tv0[i*5 +: 5] = 5'($urandom);
            tm0[i*5 +: 5] = 5'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            tv1[i*6 +: 6] = 6'($urandom);
            tm1[i*6 +: 6] = 6'($urandom);
        end
    endtask

    initial begin
        int t0;
        bit hit;
        rst = 1'b1;
        frz = 1'b0;
        pcen_n = 1'b1;
        tv0 = '0; tm0 = '0;
        rand_taps(1'b0);
        tv0[0*5 +: 5] = 5'd11;       tm0[0*5 +: 5] = 5'h1f;
        tv0[1*5 +: 5] = 5'b01110;    tm0[1*5 +: 5] = 5'b01111;
        tv0[2*5 +: 5] = 5'($urandom); tm0[2*5 +: 5] = 5'd0;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            drive_en(1'b0);
            cyc();
        end
        rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            drive_en(1'b0);
            cyc();
        end

        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            drive_en(1'b0);
            cyc();
            hit = (sl[0] == 20);
        end
        chk("wait_slot20", 32'(hit), 32'd1);
        frz = 1'b1;
        t0 = tk[0];
        for (int i = 0; i < 200 && tk[0] - t0 < 7; i++) begin
            drive_en(1'b0);
            cyc();
        end
        frz = 1'b0;
        chk("frz_hold", 32'(slot0), 32'd20);
        for (int i = 0; i < 200 && tk[0] - t0 < 8; i++) begin
            drive_en(1'b0);
            cyc();
        end
        chk("frz_resume", 32'(slot0), 32'd21);

        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            drive_en(1'b0);
            cyc();
            hit = (sl[0] == 17) && s1[0];
        end
        chk("wait_slot17", 32'(hit), 32'd1);
        chk("sh1_pre_rst", 32'(sh10), 32'd1);
        rst = 1'b1;
        drive_en(1'b0);
        cyc();
        chk("rst_sh1", 32'(sh10), 32'd0);
        chk("rst_slot", 32'(slot0), 32'd0);
        chk("rst_tap", 32'(tap0), 32'd0);
        chk("rst_mrst", 32'(mrst0), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            drive_en(1'b0);
            cyc();
        end

        for (int i = 0; i < 3000; i++) begin
            drive_en(1'b1);
            frz = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 63) == 0) rand_taps(1'b1);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
